// File: rtl/cordic_rotate_pkg.sv
// Shared constants and types for the rotation-mode CORDIC (polar -> rectangular).
package cordic_rotate_pkg;

    localparam int unsigned DW   = 18;   // magnitude / x / y width, fix18_16
    localparam int unsigned ZW   = 18;   // phase width, fix18_15 radians
    localparam int unsigned IDXW = 5;    // micro-rotation index width (0..16)
    localparam int unsigned KW   = 19;   // KINV carried as a positive signed value
    localparam int unsigned KSH  = 17;   // KINV is Q0.17

    localparam logic signed [ZW-1:0] PI   = 18'sd102944;
    localparam logic signed [ZW-1:0] PI_2 = 18'sd51472;
    localparam logic signed [KW-1:0] KINV = 19'sd79594;

    localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREROT = 3'd1,
        ST_ITER   = 3'd2,
        ST_SCALE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup in fix18_15 radians, usable by any CORDIC core.
module cordic_atan_rom
    import cordic_rotate_pkg::*;
(
    input  logic [IDXW-1:0]      i_idx,
    output logic signed [ZW-1:0] o_atan_c
);

    always_comb begin
        o_atan_c = '0;
        case (i_idx)
            5'd0:    o_atan_c = 18'sd25736;
            5'd1:    o_atan_c = 18'sd15193;
            5'd2:    o_atan_c = 18'sd8027;
            5'd3:    o_atan_c = 18'sd4075;
            5'd4:    o_atan_c = 18'sd2045;
            5'd5:    o_atan_c = 18'sd1024;
            5'd6:    o_atan_c = 18'sd512;
            5'd7:    o_atan_c = 18'sd256;
            5'd8:    o_atan_c = 18'sd128;
            5'd9:    o_atan_c = 18'sd64;
            5'd10:   o_atan_c = 18'sd32;
            5'd11:   o_atan_c = 18'sd16;
            5'd12:   o_atan_c = 18'sd8;
            5'd13:   o_atan_c = 18'sd4;
            5'd14:   o_atan_c = 18'sd2;
            5'd15:   o_atan_c = 18'sd1;
            5'd16:   o_atan_c = 18'sd1;
            default: o_atan_c = '0;
        endcase
    end

endmodule

// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC: (magnitude, phase) -> (mag*cos, mag*sin).
// Handshake and number formats match the vectoring core so the two chain directly.
module cordic_rotate
    import cordic_rotate_pkg::*;
#(
    parameter int unsigned ITER  = 16,
    parameter int unsigned GUARD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] mag_in,
    input  logic signed [ZW-1:0] phase_in,
    input  logic                 nd,
    output logic signed [DW-1:0] x_out,
    output logic signed [DW-1:0] y_out,
    output logic                 rdy,
    output logic                 busy
);

    localparam int unsigned XW = DW + 2 + GUARD;
    localparam int unsigned PW = XW + KW;
    localparam logic [IDXW-1:0]      LAST_I = IDXW'(ITER - 1);
    localparam logic signed [XW-1:0] RND    = XW'((2 ** GUARD) / 2);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDXW-1:0]        r_i;
    logic signed [DW-1:0]   r_mag;
    logic signed [ZW-1:0]   r_phase;
    logic signed [XW-1:0]   r_x;
    logic signed [XW-1:0]   r_y;
    logic signed [ZW-1:0]   r_z;
    logic signed [DW-1:0]   r_x_out;
    logic signed [DW-1:0]   r_y_out;
    logic                   r_rdy;
    logic                   r_busy;

    logic signed [ZW-1:0]   w_atan;
    logic signed [ZW-1:0]   w_z_clamp;
    logic signed [XW-1:0]   w_mag_ext;
    logic                   w_d_pos;
    logic signed [XW-1:0]   w_x_sh;
    logic signed [XW-1:0]   w_y_sh;
    logic signed [XW-1:0]   w_x_it;
    logic signed [XW-1:0]   w_y_it;
    logic signed [ZW-1:0]   w_z_it;
    logic signed [PW-1:0]   w_x_prod;
    logic signed [PW-1:0]   w_y_prod;
    logic signed [XW-1:0]   w_x_scl;
    logic signed [XW-1:0]   w_y_scl;

    // Drop the guard bits with half-up rounding, then clip to the 18-bit output range.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] rv;
        rv = (v + RND) >>> GUARD;
        if (rv > XW'(OUT_MAX))
            return OUT_MAX;
        else if (rv < XW'(OUT_MIN))
            return OUT_MIN;
        else
            return DW'(rv);
    endfunction

    cordic_atan_rom u_atan_rom (
        .i_idx    (r_i),
        .o_atan_c (w_atan)
    );

    always_comb begin
        w_z_clamp = r_phase;
        if (r_phase > PI)
            w_z_clamp = PI;
        else if (r_phase < -PI)
            w_z_clamp = -PI;
        w_mag_ext = XW'(r_mag) <<< GUARD;

        w_d_pos = ~r_z[ZW-1];
        w_x_sh  = r_x >>> r_i;
        w_y_sh  = r_y >>> r_i;
        w_x_it  = w_d_pos ? (r_x - w_y_sh) : (r_x + w_y_sh);
        w_y_it  = w_d_pos ? (r_y + w_x_sh) : (r_y - w_x_sh);
        w_z_it  = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

        // Two multipliers keep SCALE to a single cycle.
        w_x_prod = PW'(r_x) * PW'(KINV);
        w_y_prod = PW'(r_y) * PW'(KINV);
        w_x_scl  = XW'(w_x_prod >>> KSH);
        w_y_scl  = XW'(w_y_prod >>> KSH);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (nd) w_state_nxt = ST_PREROT;
            ST_PREROT: w_state_nxt = ST_ITER;
            ST_ITER:   if (r_i == LAST_I) w_state_nxt = ST_SCALE;
            ST_SCALE:  w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i     <= '0;
            r_mag   <= '0;
            r_phase <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (nd) begin
                        r_mag   <= mag_in;
                        r_phase <= phase_in;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PREROT: begin
                    // Fold into [-pi/2, +pi/2] so the micro-rotations can converge.
                    r_i <= '0;
                    if (w_z_clamp > PI_2) begin
                        r_x <= '0;
                        r_y <= w_mag_ext;
                        r_z <= w_z_clamp - PI_2;
                    end else if (w_z_clamp < -PI_2) begin
                        r_x <= '0;
                        r_y <= -w_mag_ext;
                        r_z <= w_z_clamp + PI_2;
                    end else begin
                        r_x <= w_mag_ext;
                        r_y <= '0;
                        r_z <= w_z_clamp;
                    end
                end
                ST_ITER: begin
                    r_x <= w_x_it;
                    r_y <= w_y_it;
                    r_z <= w_z_it;
                    r_i <= r_i + IDXW'(1);
                end
                ST_SCALE: begin
                    r_x <= w_x_scl;
                    r_y <= w_y_scl;
                end
                ST_DONE: begin
                    r_x_out <= round_sat(r_x);
                    r_y_out <= round_sat(r_y);
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign x_out = r_x_out;
    assign y_out = r_y_out;
    assign rdy   = r_rdy;
    assign busy  = r_busy;

endmodule
